button_debounce: RTL and testbench

- Upstream conditioning stage for the memory-mapped button/IO block.
- Synchronises NUM_BTNS raw pushbutton pins (big button, morse left/right/tx, keypad TL/TR/LL/LR) to clk and debounces each one with its own counter.
- Produces clean levels, one-cycle press/release pulses and sticky press flags; the IO block reads these in place of raw pins.
- The sticky flags let the CPU catch presses shorter than its polling interval.

---
 rtl/button_debounce.sv | 109 ++++++++++
 tb/tb_button_debounce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel synchroniser, debouncer, press/release pulses and sticky flags
// Optional long-press detection on btn_hold is built when HOLD_DETECT_EN is defined.
module button_debounce #(
   parameter int NUM_BTNS        = 8,
   parameter int CNT_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int HOLD_CYCLES     = 25000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_raw,
   input  logic [NUM_BTNS-1:0] clr_press,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic [NUM_BTNS-1:0] btn_sticky,
   output logic [NUM_BTNS-1:0] btn_hold
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTNS-1:0]  POL_MASK = ACTIVE_LOW ? '1 : '0;

   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
      $error("button_debounce: DEBOUNCE_CYCLES and HOLD_CYCLES must be at least 1");
   end

   logic [NUM_BTNS-1:0]  s1;
   logic [NUM_BTNS-1:0]  s2;
   logic [NUM_BTNS-1:0]  stb;
   logic [CNT_WIDTH-1:0] cnt [NUM_BTNS];

   // Polarity is folded in ahead of the synchroniser so everything downstream sees 1 = pressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw ^ POL_MASK;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (rst) begin
            stb[i]         <= 1'b0;
            cnt[i]         <= '0;
            btn_press[i]   <= 1'b0;
            btn_release[i] <= 1'b0;
         end else begin
            btn_press[i]   <= 1'b0;
            btn_release[i] <= 1'b0;
            if (s2[i] == stb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stb[i]         <= s2[i];
               cnt[i]         <= '0;
               btn_press[i]   <= s2[i];
               btn_release[i] <= ~s2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press arriving together with a clear must survive, so the set term dominates.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_sticky <= '0;
      end else begin
         btn_sticky <= btn_press | (btn_sticky & ~clr_press);
      end
   end

   assign btn_level = stb;

`ifdef HOLD_DETECT_EN
   localparam int             HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0]   hold_cnt [NUM_BTNS];
   logic [NUM_BTNS-1:0] hold_hit;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (rst || !stb[i]) begin
            hold_cnt[i] <= '0;
         end else if (hold_cnt[i] != HOLD_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      hold_hit = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         hold_hit[i] = (hold_cnt[i] == HOLD_MAX);
      end
   end

   // Gating with stb drops the flag on the release edge rather than one cycle later.
   assign btn_hold = hold_hit & stb;
`else
   assign btn_hold = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed and randomized checks of button_debounce against a run-length model
// HOLD_DETECT_EN selects whether btn_hold is expected to follow the long-press rule or stay 0.
module tb_button_debounce;

   localparam int NB = 8;
   localparam int CW = 8;
   localparam int DC = 4;
   localparam int HC = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] clr_press;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_sticky;
   logic [NB-1:0] btn_hold;

   always #5 clk = ~clk;

   button_debounce #(
      .NUM_BTNS(NB), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0), .HOLD_CYCLES(HC)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .clr_press(clr_press),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .btn_sticky(btn_sticky), .btn_hold(btn_hold)
   );

   int checks = 0;
   int errors = 0;

   // Model: the pin is seen two edges late; a level is accepted after DC consecutive disagreeing edges.
   logic [NB-1:0] pipe[$];
   logic [NB-1:0] m_level, m_press, m_rel, m_sticky, m_hold;
   int            m_run  [NB];
   int            m_hrun [NB];

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pipe = '{8'h00, 8'h00};
      m_level = '0; m_press = '0; m_rel = '0; m_sticky = '0; m_hold = '0;
      for (int i = 0; i < NB; i++) begin
         m_run[i]  = 0;
         m_hrun[i] = 0;
      end
   endtask

   task automatic model_edge();
      logic [NB-1:0] seen, old_press, old_level;
      if (rst) begin
         model_reset();
         return;
      end
      seen = pipe.pop_front();
      pipe.push_back(btn_raw);
      old_press = m_press;
      old_level = m_level;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NB; i++) begin
         if (seen[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DC) begin
               m_level[i] = seen[i];
               m_press[i] = seen[i];
               m_rel[i]   = ~seen[i];
               m_run[i]   = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_sticky = old_press | (m_sticky & ~clr_press);
      for (int i = 0; i < NB; i++) begin
         if (!m_level[i]) m_hrun[i] = 0;
         else if (old_level[i] && m_hrun[i] < HC) m_hrun[i]++;
`ifdef HOLD_DETECT_EN
         m_hold[i] = m_level[i] && (m_hrun[i] == HC);
`else
         m_hold[i] = 1'b0;
`endif
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         model_edge();
         @(posedge clk);
         #1;
         chk("level",   btn_level,   m_level);
         chk("press",   btn_press,   m_press);
         chk("release", btn_release, m_rel);
         chk("sticky",  btn_sticky,  m_sticky);
         chk("hold",    btn_hold,    m_hold);
         chk("press_release_excl", btn_press & btn_release, '0);
      end
   endtask

   initial begin
      int presses;
      logic hold_on;
`ifdef HOLD_DETECT_EN
      hold_on = 1'b1;
`else
      hold_on = 1'b0;
`endif
      model_reset();
      rst = 1'b1; btn_raw = '0; clr_press = '0;
      step(2);
      rst = 1'b0;
      step(20);
      chk("idle_level", btn_level, 8'h00);

      // Clean press and release on channel 0
      btn_raw[0] = 1'b1;
      step(5);
      chk("press0_early_level", {7'b0, btn_level[0]}, 8'h00);
      step(1);
      chk("press0_level", {7'b0, btn_level[0]}, 8'h01);
      chk("press0_pulse", {7'b0, btn_press[0]}, 8'h01);
      step(1);
      chk("press0_pulse_end", {7'b0, btn_press[0]}, 8'h00);
      btn_raw[0] = 1'b0;
      step(5);
      chk("release0_early", {7'b0, btn_release[0]}, 8'h00);
      step(1);
      chk("release0_pulse", {7'b0, btn_release[0]}, 8'h01);
      chk("release0_level", {7'b0, btn_level[0]}, 8'h00);

      // Glitch of 3 cycles on channel 3 is rejected
      btn_raw[3] = 1'b1;
      step(3);
      btn_raw[3] = 1'b0;
      step(10);
      chk("glitch3_level", {7'b0, btn_level[3]}, 8'h00);

      // Bounce then settle: exactly one press
      presses = 0;
      for (int b = 0; b < 5; b++) begin
         btn_raw[3] = (b % 2 == 0);
         step(1);
         presses += int'(btn_press[3]);
      end
      btn_raw[3] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         presses += int'(btn_press[3]);
      end
      chk("bounce3_presses", 8'(presses), 8'd1);

      // Reset mid-count with channel 0 held, then re-acceptance
      btn_raw[0] = 1'b1;
      step(4);
      rst = 1'b1;
      step(1);
      chk("rst_mid_level", btn_level, 8'h00);
      rst = 1'b0;
      step(5);
      chk("reaccept_early", {7'b0, btn_level[0]}, 8'h00);
      step(1);
      chk("reaccept_press", {7'b0, btn_press[0]}, 8'h01);
      btn_raw = '0;
      step(8);

      // Sticky on channel 5: set, hold, clear, then clear coinciding with press
      btn_raw[5] = 1'b1;
      step(6);
      chk("sticky5_press", {7'b0, btn_press[5]}, 8'h01);
      step(3);
      chk("sticky5_held", {7'b0, btn_sticky[5]}, 8'h01);
      clr_press[5] = 1'b1;
      step(1);
      clr_press[5] = 1'b0;
      chk("sticky5_cleared", {7'b0, btn_sticky[5]}, 8'h00);
      btn_raw[5] = 1'b0;
      step(8);
      btn_raw[5] = 1'b1;
      step(6);
      chk("sticky5_press2", {7'b0, btn_press[5]}, 8'h01);
      clr_press[5] = 1'b1;
      step(1);
      clr_press[5] = 1'b0;
      chk("sticky5_set_wins", {7'b0, btn_sticky[5]}, 8'h01);

      // Simultaneous press on every channel, then long hold
      btn_raw = '0;
      clr_press = '1;
      step(10);
      clr_press = '0;
      btn_raw = 8'hFF;
      step(5);
      chk("all_press_early", btn_press, 8'h00);
      step(1);
      chk("all_press", btn_press, 8'hFF);
      step(9);
      chk("hold_early", btn_hold, 8'h00);
      step(1);
      chk("hold_on", btn_hold, hold_on ? 8'hFF : 8'h00);
      step(5);
      btn_raw = '0;
      step(6);
      chk("hold_drop", btn_hold, 8'h00);
      chk("all_release", btn_release, 8'hFF);

      // Randomized phase: each pin flips with probability 1/6 per cycle, random clears, rare resets
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NB; i++) begin
            if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
         end
         clr_press = 8'($urandom) & 8'($urandom);
         rst = ($urandom_range(499) == 0);
         step(1);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
